// File: rtl/trace_round_ctrl.sv
// Round sequencer for the 4x4 trace grid: picks a target path, shows it, clears the
// grid, then scores the player's trace against the target within a time window.
module trace_round_ctrl #(
  parameter int unsigned SHOW_CYCLES = 32'd100000000,
  parameter int unsigned RESET_HOLD  = 32'd10000000,
  parameter int unsigned PLAY_CYCLES = 32'd500000000,
  parameter int unsigned MAX_ROUNDS  = 32'd10,
  parameter int unsigned SCORE_W     = 32'd8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        already_traced,
  output logic [15:0]        displayed_trace,
  output logic               show_trace,
  output logic               reset_trace,
  output logic               round_active,
  output logic               round_win,
  output logic [3:0]         round_num,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHOW   = 3'd2;
  localparam logic [2:0] ST_CLEAR  = 3'd3;
  localparam logic [2:0] ST_PLAY   = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam logic [3:0]         LAST_ROUND = MAX_ROUNDS[3:0];
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};

  function automatic logic [15:0] path_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    path_rom = 16'h000F;
      3'd1:    path_rom = 16'h1111;
      3'd2:    path_rom = 16'h8421;
      3'd3:    path_rom = 16'h1248;
      3'd4:    path_rom = 16'hF000;
      3'd5:    path_rom = 16'h8888;
      3'd6:    path_rom = 16'h0660;
      3'd7:    path_rom = 16'h9009;
      default: path_rom = 16'h0000;
    endcase
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    lfsr_next = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [2:0]  state_r;
  logic [31:0] counter_r;
  logic [15:0] lfsr_r;
  logic [15:0] pattern_r;
  logic [2:0]  prev_idx_r;
  logic        first_r;
  logic [2:0]  raw_idx_s;
  logic [2:0]  sel_idx_s;
  logic        match_s;

  assign match_s = (already_traced == pattern_r);

  // Path index: never repeat the previous round's path, except on the very first round after reset
  always_comb begin
    raw_idx_s = lfsr_r[2:0];
    if (!first_r && (raw_idx_s == prev_idx_r)) begin
      sel_idx_s = raw_idx_s + 3'd1;
    end else begin
      sel_idx_s = raw_idx_s;
    end
  end

  // Round FSM with all outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      counter_r       <= 32'd0;
      lfsr_r          <= 16'hACE1;
      pattern_r       <= 16'h0000;
      prev_idx_r      <= 3'd0;
      first_r         <= 1'b1;
      displayed_trace <= 16'h0000;
      show_trace      <= 1'b0;
      reset_trace     <= 1'b0;
      round_active    <= 1'b0;
      round_win       <= 1'b0;
      round_num       <= 4'd0;
      score           <= {SCORE_W{1'b0}};
      game_over       <= 1'b0;
    end else begin
      lfsr_r      <= lfsr_next(lfsr_r);
      reset_trace <= 1'b0;
      round_win   <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r   <= ST_LOAD;
            score     <= {SCORE_W{1'b0}};
            round_num <= 4'd0;
            game_over <= 1'b0;
          end
        end
        ST_LOAD: begin
          pattern_r       <= path_rom(sel_idx_s);
          displayed_trace <= path_rom(sel_idx_s);
          prev_idx_r      <= sel_idx_s;
          first_r         <= 1'b0;
          counter_r       <= 32'd0;
          show_trace      <= 1'b1;
          state_r         <= ST_SHOW;
        end
        ST_SHOW: begin
          if (counter_r == SHOW_CYCLES - 32'd1) begin
            show_trace  <= 1'b0;
            reset_trace <= 1'b1;
            counter_r   <= 32'd0;
            state_r     <= ST_CLEAR;
          end else begin
            counter_r <= counter_r + 32'd1;
          end
        end
        ST_CLEAR: begin
          if (counter_r == RESET_HOLD - 32'd1) begin
            round_active <= 1'b1;
            counter_r    <= 32'd0;
            state_r      <= ST_PLAY;
          end else begin
            counter_r <= counter_r + 32'd1;
          end
        end
        ST_PLAY: begin
          // A match on the timeout cycle still wins
          if (match_s || (counter_r == PLAY_CYCLES - 32'd1)) begin
            round_active <= 1'b0;
            round_num    <= round_num + 4'd1;
            state_r      <= ST_RESULT;
            if (match_s) begin
              round_win <= 1'b1;
              if (score != SCORE_MAX) begin
                score <= score + SCORE_ONE;
              end
            end
          end else begin
            counter_r <= counter_r + 32'd1;
          end
        end
        ST_RESULT: begin
          displayed_trace <= 16'h0000;
          if (round_num == LAST_ROUND) begin
            game_over <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        default: begin
          state_r         <= ST_IDLE;
          displayed_trace <= 16'h0000;
          show_trace      <= 1'b0;
          round_active    <= 1'b0;
          game_over       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_round_ctrl.sv
// Self-checking bench for trace_round_ctrl: directed timeline checks plus randomized
// rounds compared every cycle against a phase-level reference model.
module tb_trace_round_ctrl;
  localparam int SHOW_C = 4;
  localparam int HOLD_C = 2;
  localparam int PLAY_C = 8;
  localparam int MAX_R  = 3;
  localparam int SW     = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   already_traced = 16'h0000;
  logic [15:0]   displayed_trace;
  logic          show_trace, reset_trace, round_active, round_win, game_over;
  logic [3:0]    round_num;
  logic [SW-1:0] score;

  trace_round_ctrl #(
    .SHOW_CYCLES(SHOW_C), .RESET_HOLD(HOLD_C), .PLAY_CYCLES(PLAY_C),
    .MAX_ROUNDS(MAX_R), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .already_traced(already_traced),
    .displayed_trace(displayed_trace), .show_trace(show_trace), .reset_trace(reset_trace),
    .round_active(round_active), .round_win(round_win), .round_num(round_num),
    .score(score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: which phase of the round we are in and how long we have been there
  typedef enum int {P_IDLE, P_LOAD, P_SHOW, P_CLEAR, P_PLAY, P_RESULT, P_DONE} phase_t;
  logic [15:0] rom [8] = '{16'h000F, 16'h1111, 16'h8421, 16'h1248,
                           16'hF000, 16'h8888, 16'h0660, 16'h9009};
  phase_t      m_ph = P_IDLE;
  int          m_t, m_prev, m_score, m_rounds, m_idx;
  bit          m_first, m_win, m_valid = 1'b0;
  logic [15:0] m_lfsr, m_pat, m_cur;
  logic [15:0] last_pat;
  bit          have_last = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    int fb;
    fb = ((int'(l) >> 15) ^ (int'(l) >> 13) ^ (int'(l) >> 12) ^ (int'(l) >> 10)) & 1;
    return 16'(((int'(l) << 1) | fb) & 32'hFFFF);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_ph = P_IDLE; m_t = 0; m_lfsr = 16'hACE1; m_prev = 0; m_first = 1'b1;
      m_score = 0; m_rounds = 0; m_win = 1'b0; m_pat = 16'h0000; m_valid = 1'b1;
    end else begin
      m_cur  = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      case (m_ph)
        P_IDLE, P_DONE: if (start) begin m_ph = P_LOAD; m_score = 0; m_rounds = 0; end
        P_LOAD: begin
          m_idx = int'(m_cur) % 8;
          if (!m_first && m_idx == m_prev) m_idx = (m_idx + 1) % 8;
          m_pat = rom[m_idx]; m_prev = m_idx; m_first = 1'b0;
          m_ph = P_SHOW; m_t = 0;
        end
        P_SHOW:  if (m_t == SHOW_C - 1) begin m_ph = P_CLEAR; m_t = 0; end else m_t++;
        P_CLEAR: if (m_t == HOLD_C - 1) begin m_ph = P_PLAY; m_t = 0; end else m_t++;
        P_PLAY: begin
          m_win = (already_traced == m_pat);
          if (m_win || m_t == PLAY_C - 1) begin
            if (m_win && m_score < (1 << SW) - 1) m_score++;
            m_rounds++;
            m_ph = P_RESULT;
          end else m_t++;
        end
        P_RESULT: m_ph = (m_rounds == MAX_R) ? P_DONE : P_LOAD;
        default:  m_ph = P_IDLE;
      endcase
    end
  endtask

  function automatic logic [39:0] exp_vec();
    logic [15:0] d;
    d = (m_ph inside {P_SHOW, P_CLEAR, P_PLAY, P_RESULT}) ? m_pat : 16'h0000;
    return {7'd0, d, m_ph == P_SHOW, (m_ph == P_CLEAR) && (m_t == 0), m_ph == P_PLAY,
            (m_ph == P_RESULT) && m_win, 4'(m_rounds), 8'(m_score), m_ph == P_DONE};
  endfunction

  function automatic logic [39:0] dut_vec();
    return {7'd0, displayed_trace, show_trace, reset_trace, round_active, round_win,
            round_num, score, game_over};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (m_valid) check_eq("outputs", dut_vec(), exp_vec());
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Waits for PLAY, optionally throwing noise at the grid input meanwhile
  task automatic wait_active(input bit noise);
    int n = 0;
    while (!round_active && n < 200) begin
      if (noise) already_traced = ($urandom_range(0, 1) == 0) ? displayed_trace : 16'($urandom);
      tick(); n++;
    end
    if (!round_active) check_eq("wait_play", 40'd0, 40'd1);
    already_traced = 16'h0000;
    if (have_last) check_eq("distinct", {39'd0, displayed_trace != last_pat}, 40'd1);
    last_pat = displayed_trace; have_last = 1'b1;
  endtask

  task automatic wait_round_end();
    int n = 0;
    while (round_active && n < 50) begin tick(); n++; end
    if (round_active) check_eq("wait_result", 40'd0, 40'd1);
    already_traced = 16'h0000;
  endtask

  // mode 0: match on PLAY cycle k; 1: superset; 2: random; 3: match only while clearing
  task automatic play_round(input int mode, input int k);
    logic [15:0] np;
    int n;
    case (mode)
      0: begin
        wait_active(1'b1);
        repeat (k - 1) tick();
        already_traced = displayed_trace; tick();
      end
      1: begin
        wait_active(1'b1);
        np = ~displayed_trace;
        already_traced = displayed_trace | (np & (~np + 16'd1));
      end
      2: begin
        wait_active(1'b1);
        n = 0;
        while (round_active && n < 20) begin
          case ($urandom_range(0, 3))
            0:       already_traced = displayed_trace;
            1:       already_traced = displayed_trace ^ (16'd1 << $urandom_range(0, 15));
            2:       already_traced = 16'($urandom);
            default: already_traced = 16'h0000;
          endcase
          tick(); n++;
        end
      end
      default: begin
        n = 0;
        while (!reset_trace && n < 200) begin tick(); n++; end
        if (!reset_trace) check_eq("wait_clear", 40'd0, 40'd1);
        already_traced = displayed_trace;
        tick(); tick();
        already_traced = 16'h0000;
        last_pat = displayed_trace; have_last = 1'b1;
      end
    endcase
    wait_round_end();
  endtask

  initial begin
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick();
    // Directed timeline: start seen at cycle 0
    start = 1'b1; tick(); start = 1'b0;
    check_eq("load_show", {39'd0, show_trace}, 40'd0);
    check_eq("load_disp", {24'd0, displayed_trace}, 40'd0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check_eq("show_on", {38'd0, show_trace, reset_trace}, 40'd2);
    end
    tick(); check_eq("rst_pulse", {38'd0, show_trace, reset_trace}, 40'd1);
    tick(); check_eq("clear_gap", {38'd0, reset_trace, round_active}, 40'd0);
    tick(); check_eq("play_on", {39'd0, round_active}, 40'd1);
    last_pat = displayed_trace; have_last = 1'b1;
    tick(); tick();
    already_traced = displayed_trace; tick(); already_traced = 16'h0000;
    check_eq("win1", {27'd0, round_win, round_num, score}, {27'd0, 1'b1, 4'd1, 8'd1});
    tick(); check_eq("next_load", {23'd0, round_win, displayed_trace}, 40'd0);

    play_round(1, 0);
    check_eq("super_loss", {27'd0, round_win, round_num, score}, {27'd0, 1'b0, 4'd2, 8'd1});
    play_round(0, PLAY_C);
    check_eq("edge_win", {27'd0, round_win, round_num, score}, {27'd0, 1'b1, 4'd3, 8'd2});
    tick();
    check_eq("done", {10'd0, game_over, displayed_trace, round_num, score},
             {10'd0, 1'b1, 16'h0000, 4'd3, 8'd2});

    pulse_start();
    check_eq("restart", {27'd0, game_over, round_num, score}, 40'd0);
    play_round(3, 0);
    check_eq("clear_ign", {27'd0, round_win, round_num, score}, {27'd0, 1'b0, 4'd1, 8'd0});
    play_round(2, 0);
    play_round(2, 0);
    tick();
    check_eq("done2", {39'd0, game_over}, 40'd1);

    // Reset in the middle of PLAY
    pulse_start();
    wait_active(1'b0);
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    have_last = 1'b0;
    check_eq("reset_all0", dut_vec(), 40'd0);
    tick();
    pulse_start();

    for (int r = 0; r < 12; r++) begin
      play_round($urandom_range(0, 2), $urandom_range(1, PLAY_C));
      tick();
      if (game_over) pulse_start();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
